// File: rtl/load_align_if.sv
// load_align_if: request / bus / response bundle for load_align_ext.
//   req_*  : load request from the memory stage (valid/ready, byte address,
//            size code 0..3 = 1/2/4/8 bytes, sign-extend flag)
//   bus_*  : aligned bus read (strobe held until ack, little-endian data)
//   rsp_*  : one-cycle result pulse, extended data, address-error flag
// slave  = the load unit's view, master = the surrounding pipeline / memory.
interface load_align_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [1:0]    req_size;
  logic          req_sign;
  logic          bus_req;
  logic [AW-1:0] bus_addr;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;

  modport slave (
    input  req_valid, req_addr, req_size, req_sign, bus_ack, bus_rdata,
    output req_ready, bus_req, bus_addr, rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_addr, req_size, req_sign, bus_ack, bus_rdata,
    input  req_ready, bus_req, bus_addr, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/load_align_ext.sv
// load_align_ext: load-path align/extend unit.
// Takes one load request at a time, reads the enclosing bus word (and the
// following one when the access straddles a word boundary), right-aligns the
// addressed bytes, sign/zero-extends to DW and returns a one-cycle rsp_valid.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   io   - load_align_if.slave (req_*, bus_*, rsp_* signals)
// Parameters: DW = data width (32 or 64), AW = byte address width.
// Build option: LOAD_ALIGN_UNALIGNED_EN enables the two-beat split for
// word-crossing accesses; without it any access not naturally aligned to its
// size is answered with rsp_err and no bus traffic.
module load_align_ext #(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  load_align_if.slave   io
);

  localparam int NB = DW / 8;
  localparam int OW = $clog2(NB);

`ifdef LOAD_ALIGN_UNALIGNED_EN
  typedef enum logic [1:0] {IDLE, RD0, RD1, RESP} state_t;
`else
  typedef enum logic [1:0] {IDLE, RD0, RESP} state_t;
`endif

  state_t        state;
  logic [OW-1:0] off_q;
  logic [1:0]    size_q;
  logic          sign_q;
  logic [DW-1:0] beat0;
  logic [DW-1:0] beat1;
`ifdef LOAD_ALIGN_UNALIGNED_EN
  logic          cross_q;
`endif

  // Shift the two-word window down by the byte offset, keep 1<<size bytes,
  // fill the rest with the kept MSB (signed) or zeros.
  function automatic logic [DW-1:0] align_ext(input logic [2*DW-1:0] pair,
                                              input logic [OW-1:0]   off,
                                              input logic [1:0]      size,
                                              input logic            sgn);
    logic [2*DW-1:0] sh;
    logic [DW-1:0]   keep;
    logic            msb;
    int              nb;
    sh   = pair >> {off, 3'b000};
    nb   = 8 << size;
    keep = ~({DW{1'b1}} << nb);
    case (size)
      2'd0:    msb = sh[7];
      2'd1:    msb = sh[15];
      2'd2:    msb = sh[31];
      default: msb = sh[DW-1];
    endcase
    return (sh[DW-1:0] & keep) | ({DW{sgn & msb}} & ~keep);
  endfunction

  // Request classification, evaluated on the incoming request.
  logic [OW-1:0] in_off;
  logic [3:0]    in_bytes;
  logic          in_err;
`ifdef LOAD_ALIGN_UNALIGNED_EN
  logic          in_cross;
`endif

  always_comb begin
    in_off   = io.req_addr[OW-1:0];
    in_bytes = 4'd1 << io.req_size;
`ifdef LOAD_ALIGN_UNALIGNED_EN
    in_cross = (int'(in_off) + int'(in_bytes)) > NB;
    in_err   = int'(in_bytes) > NB;
`else
    // A naturally aligned access can never cross, so misalignment alone
    // covers the crossing case.
    in_err   = (int'(in_bytes) > NB) ||
               ((int'(in_off) & (int'(in_bytes) - 1)) != 0);
`endif
  end

  // Beat values as they will be after this edge, so the result register can
  // be loaded in the same cycle as the final ack.
  logic [DW-1:0] beat0_n, beat1_n;

  always_comb begin
    beat0_n = beat0;
    beat1_n = beat1;
    if (state == RD0 && io.bus_ack) beat0_n = io.bus_rdata;
`ifdef LOAD_ALIGN_UNALIGNED_EN
    if (state == RD1 && io.bus_ack) beat1_n = io.bus_rdata;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      io.req_ready <= 1'b1;
      io.bus_req   <= 1'b0;
      io.bus_addr  <= '0;
      io.rsp_valid <= 1'b0;
      io.rsp_data  <= '0;
      io.rsp_err   <= 1'b0;
      off_q        <= '0;
      size_q       <= '0;
      sign_q       <= 1'b0;
      beat0        <= '0;
      beat1        <= '0;
`ifdef LOAD_ALIGN_UNALIGNED_EN
      cross_q      <= 1'b0;
`endif
    end else begin
      io.rsp_valid <= 1'b0;
      case (state)
        IDLE: if (io.req_valid && io.req_ready) begin
          off_q        <= in_off;
          size_q       <= io.req_size;
          sign_q       <= io.req_sign;
          io.req_ready <= 1'b0;
`ifdef LOAD_ALIGN_UNALIGNED_EN
          cross_q      <= in_cross;
`endif
          if (in_err) begin
            state        <= RESP;
            io.rsp_valid <= 1'b1;
            io.rsp_err   <= 1'b1;
            io.rsp_data  <= '0;
          end else begin
            state       <= RD0;
            io.bus_req  <= 1'b1;
            io.bus_addr <= {io.req_addr[AW-1:OW], {OW{1'b0}}};
          end
        end
        RD0: if (io.bus_ack) begin
          beat0 <= io.bus_rdata;
`ifdef LOAD_ALIGN_UNALIGNED_EN
          if (cross_q) begin
            state       <= RD1;
            io.bus_addr <= io.bus_addr + AW'(NB);  // wraps at top of space
          end else
`endif
          begin
            state        <= RESP;
            io.bus_req   <= 1'b0;
            io.rsp_valid <= 1'b1;
            io.rsp_err   <= 1'b0;
            io.rsp_data  <= align_ext({beat1_n, beat0_n}, off_q, size_q, sign_q);
          end
        end
`ifdef LOAD_ALIGN_UNALIGNED_EN
        RD1: if (io.bus_ack) begin
          beat1        <= io.bus_rdata;
          state        <= RESP;
          io.bus_req   <= 1'b0;
          io.rsp_valid <= 1'b1;
          io.rsp_err   <= 1'b0;
          io.rsp_data  <= align_ext({beat1_n, beat0_n}, off_q, size_q, sign_q);
        end
`endif
        RESP: begin
          state        <= IDLE;
          io.req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_align_ext.sv
// Directed bench for load_align_ext (DW=32): vector table of loads against a
// four-word memory model, plus reset-during-read and stray-ack sequences.
// Expectations follow the LOAD_ALIGN_UNALIGNED_EN build setting.
module tb_load_align_ext;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_align_if #(.DW(32), .AW(32)) io ();

  load_align_ext #(.DW(32), .AW(32)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'hF1E2_D3C4;
      32'h0000_0104: return 32'h0A0B_0C0D;
      32'hFFFF_FFFC: return 32'h1122_3344;
      32'h0000_0000: return 32'h5566_7788;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Bus responder: acks after ack_delay idle cycles per beat; stray drives
  // an ack while no read is outstanding.
  int ack_delay = 0;
  int wcnt = 0;
  bit stray = 1'b0;

  initial begin
    io.bus_ack   = 1'b0;
    io.bus_rdata = '0;
  end

  always @(posedge clk) begin
    #1;
    if (io.bus_ack) wcnt = 0;
    if (stray) begin
      io.bus_ack   = 1'b1;
      io.bus_rdata = 32'hFFFF_FFFF;
    end else if (io.bus_req && !rst) begin
      if (wcnt >= ack_delay) begin
        io.bus_ack   = 1'b1;
        io.bus_rdata = mem_rd(io.bus_addr);
      end else begin
        io.bus_ack   = 1'b0;
        io.bus_rdata = 32'hBAD0_BAD0;
        wcnt++;
      end
    end else begin
      io.bus_ack = 1'b0;
      wcnt = 0;
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sign;
    int          delay;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_beats;
    int          exp_lat;
    logic [31:0] a0;
    logic [31:0] a1;
  } vec_t;

  vec_t vecs[$];

  task automatic run_vec(input vec_t v);
    logic [31:0] addrs[2];
    int lat, acks, reqc;
    bit got;
    addrs[0] = '0;
    addrs[1] = '0;
    @(negedge clk);
    chk("ready_idle", io.req_ready, 1);
    io.req_valid = 1'b1;
    io.req_addr  = v.addr;
    io.req_size  = v.size;
    io.req_sign  = v.sign;
    ack_delay    = v.delay;
    @(posedge clk);
    @(negedge clk);
    io.req_valid = 1'b0;
    chk("ready_busy", io.req_ready, 0);
    lat = 1; acks = 0; reqc = 0; got = 1'b0;
    while (!got && lat <= 30) begin
      if (io.bus_req) reqc++;
      if (io.bus_req && io.bus_ack) begin
        if (acks < 2) addrs[acks] = io.bus_addr;
        acks++;
      end
      if (io.rsp_valid) got = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    chk("rsp_seen", got, 1);
    chk("latency", lat, v.exp_lat);
    chk("rsp_data", io.rsp_data, v.exp_data);
    chk("rsp_err", io.rsp_err, v.exp_err);
    chk("beats", acks, v.exp_beats);
    chk("bus_req_cycles", reqc, (v.exp_beats > 0) ? v.exp_lat - 1 : 0);
    if (v.exp_beats > 0) chk("bus_addr0", addrs[0], v.a0);
    if (v.exp_beats > 1) chk("bus_addr1", addrs[1], v.a1);
    @(negedge clk);
    chk("pulse_width", io.rsp_valid, 0);
    chk("ready_back", io.req_ready, 1);
    chk("data_hold", io.rsp_data, v.exp_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nv;
    io.req_valid = 1'b0;
    io.req_addr  = '0;
    io.req_size  = '0;
    io.req_sign  = 1'b0;

    //             addr           sz  sg dly data           err beats lat a0             a1
    vecs.push_back('{32'h0000_0103, 2'd0, 1, 0, 32'hFFFF_FFF1, 0, 1, 2, 32'h0000_0100, 32'h0});
    vecs.push_back('{32'h0000_0103, 2'd0, 0, 0, 32'h0000_00F1, 0, 1, 2, 32'h0000_0100, 32'h0});
    vecs.push_back('{32'h0000_0102, 2'd1, 1, 3, 32'hFFFF_F1E2, 0, 1, 5, 32'h0000_0100, 32'h0});
    vecs.push_back('{32'h0000_0102, 2'd1, 0, 0, 32'h0000_F1E2, 0, 1, 2, 32'h0000_0100, 32'h0});
    vecs.push_back('{32'h0000_0100, 2'd0, 1, 0, 32'hFFFF_FFC4, 0, 1, 2, 32'h0000_0100, 32'h0});
    vecs.push_back('{32'h0000_0100, 2'd1, 0, 1, 32'h0000_D3C4, 0, 1, 3, 32'h0000_0100, 32'h0});
    vecs.push_back('{32'h0000_0104, 2'd2, 1, 0, 32'h0A0B_0C0D, 0, 1, 2, 32'h0000_0104, 32'h0});
    vecs.push_back('{32'h0000_0106, 2'd1, 1, 0, 32'h0000_0A0B, 0, 1, 2, 32'h0000_0104, 32'h0});
    vecs.push_back('{32'h0000_0000, 2'd0, 0, 0, 32'h0000_0088, 0, 1, 2, 32'h0000_0000, 32'h0});
    vecs.push_back('{32'h0000_0001, 2'd0, 1, 0, 32'h0000_0077, 0, 1, 2, 32'h0000_0000, 32'h0});
    vecs.push_back('{32'h0000_0104, 2'd3, 1, 0, 32'h0000_0000, 1, 0, 1, 32'h0,         32'h0});
`ifdef LOAD_ALIGN_UNALIGNED_EN
    vecs.push_back('{32'h0000_0102, 2'd2, 0, 0, 32'h0C0D_F1E2, 0, 2, 3, 32'h0000_0100, 32'h0000_0104});
    vecs.push_back('{32'h0000_0103, 2'd1, 1, 0, 32'h0000_0DF1, 0, 2, 3, 32'h0000_0100, 32'h0000_0104});
    vecs.push_back('{32'hFFFF_FFFE, 2'd2, 0, 0, 32'h7788_1122, 0, 2, 3, 32'hFFFF_FFFC, 32'h0000_0000});
    vecs.push_back('{32'h0000_0101, 2'd2, 1, 1, 32'h0DF1_E2D3, 0, 2, 5, 32'h0000_0100, 32'h0000_0104});
`else
    vecs.push_back('{32'h0000_0102, 2'd2, 0, 0, 32'h0000_0000, 1, 0, 1, 32'h0,         32'h0});
    vecs.push_back('{32'h0000_0103, 2'd1, 1, 0, 32'h0000_0000, 1, 0, 1, 32'h0,         32'h0});
    vecs.push_back('{32'hFFFF_FFFE, 2'd2, 0, 0, 32'h0000_0000, 1, 0, 1, 32'h0,         32'h0});
    vecs.push_back('{32'h0000_0101, 2'd1, 1, 0, 32'h0000_0000, 1, 0, 1, 32'h0,         32'h0});
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", io.req_ready, 1);
    chk("rst_bus_req",   io.bus_req, 0);
    chk("rst_bus_addr",  io.bus_addr, 0);
    chk("rst_rsp_valid", io.rsp_valid, 0);
    chk("rst_rsp_data",  io.rsp_data, 0);
    chk("rst_rsp_err",   io.rsp_err, 0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while a read is outstanding: drop bus_req at once, no response.
    @(negedge clk);
`ifdef LOAD_ALIGN_UNALIGNED_EN
    io.req_addr = 32'h0000_0102; io.req_size = 2'd2; ack_delay = 2;
`else
    io.req_addr = 32'h0000_0100; io.req_size = 2'd2; ack_delay = 4;
`endif
    io.req_sign  = 1'b0;
    io.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_bus_req", io.bus_req, 1);
`ifdef LOAD_ALIGN_UNALIGNED_EN
    chk("mid_bus_addr_rd1", io.bus_addr, 32'h0000_0104);
`else
    chk("mid_bus_addr_rd0", io.bus_addr, 32'h0000_0100);
`endif
    rst = 1'b1;
    #1;
    chk("arst_bus_req", io.bus_req, 0);
    chk("arst_req_ready", io.req_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    repeat (6) begin
      @(negedge clk);
      if (io.rsp_valid) nv++;
    end
    chk("arst_no_rsp", nv, 0);
    chk("arst_idle_bus", io.bus_req, 0);

    // Acks with no read outstanding must be ignored.
    @(negedge clk);
    stray = 1'b1;
    nv = 0;
    repeat (4) begin
      @(negedge clk);
      if (io.rsp_valid || io.bus_req || !io.req_ready) nv++;
    end
    stray = 1'b0;
    chk("stray_ack_ignored", nv, 0);
    repeat (2) @(negedge clk);

    // Normal operation after reset and stray acks.
    run_vec(vecs[0]);
    run_vec(vecs[10]);
    run_vec(vecs[6]);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/load_align_ext.md
Name: load_align_ext

Overview:
Parametrised load-path unit between the memory-stage request and the data bus. It accepts a load request with byte address, size and signedness, and issues one aligned bus read, or two when the access crosses a bus word. It then merges and right-aligns the selected bytes, sign- or zero-extends them to DW bits, and returns the result with a one-cycle valid pulse.

Parameters:
DW, 32, bus/register data width in bits; 32 or 64.
AW, 32, byte-address width.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
req_valid  in  1  load request present.
req_ready  out  1  unit can accept a request (state IDLE).
req_addr  in  AW  byte address.
req_size  in  2  access size: 0 byte, 1 half, 2 word, 3 dword.
req_sign  in  1  1 = sign-extend, 0 = zero-extend.
bus_req  out  1  bus read strobe, held until bus_ack.
bus_addr  out  AW  bus-word-aligned read address.
bus_ack  in  1  read data valid this cycle.
bus_rdata  in  DW  read data, little-endian (byte 0 = bits 7:0).
rsp_valid  out  1  one-cycle result pulse.
rsp_data  out  DW  extended result, held until the next response.
rsp_err  out  1  address-error flag, qualified by rsp_valid.

Behaviour:
- Reset values: req_ready=1; bus_req, bus_addr, rsp_valid, rsp_data, rsp_err all 0; state IDLE; both beat registers 0.
- Definitions: NB = DW/8; bytes = 1<<req_size; off = req_addr mod NB; base = req_addr with its low log2(NB) bits cleared.
- Crossing: off+bytes > NB.
- Illegal size: bytes > NB (size 3 with DW=32) gives rsp_err=1.
- States: IDLE, RD0, RD1, RESP.
- IDLE:
  - Accept when req_valid & req_ready, then latch addr, size and sign.
  - Illegal size, or crossing with the feature disabled: go to RESP with err=1. No bus access is made.
  - Otherwise go to RD0.
- RD0: bus_req=1, bus_addr=base.
  - On bus_ack, capture bus_rdata into beat0.
  - If crossing, go to RD1; else go to RESP.
- RD1: bus_req=1, bus_addr=(base+NB) mod 2^AW; at the top of the address space this wraps to 0.
  - On bus_ack, capture into beat1 and go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then go to IDLE.
  - rsp_data = ({beat1,beat0} >> 8*off) truncated to `bytes` bytes, then extended to DW using req_sign.
  - Dword on DW=64 has no extension.
  - On error, rsp_data=0 and rsp_err=1.
- Timing:
  - bus_ack may arrive in the same cycle bus_req first rises (zero wait). Arbitrary wait states are allowed.
  - bus_ack outside RD0/RD1 is ignored.
  - bus_addr is stable while bus_req=1.
- Latency: accept at T gives bus_req from T+1. With zero-wait acks, rsp_valid is at T+2 for 1 beat and T+3 for 2 beats. Error responses appear at T+1.
- req_ready is 0 from the accept cycle+1 until the cycle after RESP. No request overlap.
- Reset mid-operation: immediate return to IDLE with bus_req=0. Partial beats are discarded and no rsp_valid is issued.
- rsp_err clears on the next response.

Optional Feature:
Macro LOAD_ALIGN_UNALIGNED_EN.
- Defined: crossing accesses are split into RD0+RD1 and merged as above (MIPS LWL/LWR-style support without software).
- Undefined: the RD1 state is omitted. Any access with off mod bytes != 0 responds with rsp_err=1 and rsp_data=0 at T+1, with no bus traffic. This maps to the AdEL exception.

Test Plan:
Memory, DW=32: word 0x100=0xF1E2D3C4, word 0x104=0x0A0B0C0D, word 0xFFFFFFFC=0x11223344, word 0x0=0x55667788. Zero-wait acks unless stated.
1. LB sign addr 0x103 -> one bus read at 0x100, rsp_data=0xFFFFFFF1. The same request with sign=0 -> 0x000000F1.
2. LH sign addr 0x102, bus_ack delayed 3 cycles -> bus_req held 4 cycles with bus_addr=0x100, rsp_data=0xFFFFF1E2, rsp_valid width 1.
3. LW addr 0x102, macro on -> reads 0x100 then 0x104, rsp_data=0x0C0DF1E2, rsp_err=0. Macro off -> no bus_req, rsp_err=1, rsp_data=0 at T+1.
4. LH sign addr 0x103, macro on -> two beats, rsp_data=0x00000DF1.
5. LW addr 0xFFFFFFFE, macro on -> bus_addr 0xFFFFFFFC then 0x00000000, rsp_data=0x77881122.
6. Assert rst during RD1 -> bus_req=0 and req_ready=1 immediately, no rsp_valid. A size=3 request on DW=32 -> rsp_err=1.
